// File: rtl/blink_pkg.sv
// Shared definitions for the blink timer / blink period meter family:
// the meter FSM state encoding and the default counter width.
package blink_pkg;

  localparam int BLINK_WIDTH = 27;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RISE = 3'd1,
    MEAS_HIGH = 3'd2,
    MEAS_LOW  = 3'd3,
    DONE      = 3'd4
  } blink_state_e;

endpackage

// File: rtl/blink_edge_sync.sv
// Two-flop synchronizer for the asynchronous blink input plus a third
// registered copy used to detect rising and falling edges of the synced level.
module blink_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic blink_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // synchronizer chain and delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= blink_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign level = sync2_r;
  assign rise  = sync2_r & ~prev_r;
  assign fall  = ~sync2_r & prev_r;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period and high time of an asynchronous blink waveform in clk cycles.
// Optional no-edge abort with timeout port: define BLINK_METER_TIMEOUT_EN.
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int N = BLINK_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blink_in,
  input  logic         start,
  input  logic         ack,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         overflow
`ifdef BLINK_METER_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

`ifdef BLINK_METER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  blink_state_e state_r;
  logic [N-1:0] cnt_r;
  logic [N-1:0] cnt_inc_s;
  logic         sat_s;
  logic         force_done_s;
  logic         level_unused_s;
  logic         rise_s;
  logic         fall_s;

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    if (v == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  blink_edge_sync u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .blink_in (blink_in),
    .level    (level_unused_s),
    .rise     (rise_s),
    .fall     (fall_s)
  );

  // saturating increment and the no-edge abort condition (edges take priority)
  always_comb begin
    cnt_inc_s    = sat_inc(cnt_r);
    sat_s        = (cnt_inc_s == CNT_MAX);
    force_done_s = 1'b0;
    case (state_r)
      WAIT_RISE: force_done_s = TIMEOUT_EN && sat_s && !rise_s;
      MEAS_HIGH: force_done_s = TIMEOUT_EN && sat_s && !fall_s;
      MEAS_LOW:  force_done_s = TIMEOUT_EN && sat_s && !rise_s;
      default:   force_done_s = 1'b0;
    endcase
  end

  // measurement FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= WAIT_RISE;
            busy     <= 1'b1;
            cnt_r    <= '0;
            overflow <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (rise_s) begin
            state_r <= MEAS_HIGH;
            cnt_r   <= CNT_ONE;
          end else begin
            if (TIMEOUT_EN) begin
              cnt_r <= cnt_inc_s;
            end
            if (force_done_s) begin
              state_r   <= DONE;
              valid     <= 1'b1;
              overflow  <= 1'b1;
              period    <= CNT_MAX;
              high_time <= CNT_MAX;
            end
          end
        end
        MEAS_HIGH: begin
          cnt_r <= cnt_inc_s;
          if (sat_s) begin
            overflow <= 1'b1;
          end
          if (fall_s) begin
            state_r   <= MEAS_LOW;
            high_time <= cnt_r;
          end else if (force_done_s) begin
            state_r   <= DONE;
            valid     <= 1'b1;
            period    <= CNT_MAX;
            high_time <= CNT_MAX;
          end
        end
        MEAS_LOW: begin
          cnt_r <= cnt_inc_s;
          if (rise_s) begin
            state_r <= DONE;
            valid   <= 1'b1;
            period  <= cnt_r;
          end else begin
            if (sat_s) begin
              overflow <= 1'b1;
            end
            if (force_done_s) begin
              state_r <= DONE;
              valid   <= 1'b1;
              period  <= CNT_MAX;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here, even alongside ack
          if (ack) begin
            state_r <= IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BLINK_METER_TIMEOUT_EN
  // sticky no-edge abort flag, cleared by a new measurement request
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      timeout <= 1'b0;
    end else if (force_done_s) begin
      timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_blink_period_meter.sv
// Scoreboard bench for blink_period_meter: a default-width instance and an
// N=4 instance for saturation (and, with BLINK_METER_TIMEOUT_EN, timeout).
`timescale 1ns/1ps
module tb_blink_period_meter;

  typedef struct {
    logic [26:0] period;
    logic [26:0] high;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        blink_a, start_a, ack_a, busy_a, valid_a, ovf_a;
  logic [26:0] period_a, high_a;
  logic        blink_b, start_b, ack_b, busy_b, valid_b, ovf_b;
  logic [3:0]  period_b, high_b;
`ifdef BLINK_METER_TIMEOUT_EN
  logic        to_a, to_b;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  bit   wave_on = 1'b0;
  int   hi_len = 5;
  int   lo_len = 7;
  int   ph = 0;

  always #5 clk = ~clk;

  blink_period_meter dut_a (
    .clk(clk), .rst(rst), .blink_in(blink_a), .start(start_a), .ack(ack_a),
    .busy(busy_a), .valid(valid_a), .period(period_a), .high_time(high_a),
    .overflow(ovf_a)
`ifdef BLINK_METER_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  blink_period_meter #(.N(4)) dut_b (
    .clk(clk), .rst(rst), .blink_in(blink_b), .start(start_b), .ack(ack_b),
    .busy(busy_b), .valid(valid_b), .period(period_b), .high_time(high_b),
    .overflow(ovf_b)
`ifdef BLINK_METER_TIMEOUT_EN
    , .timeout(to_b)
`endif
  );

  // square-wave source for dut_a: hi_len cycles high, lo_len cycles low
  initial begin
    blink_a = 1'b0;
    forever begin
      @(negedge clk);
      if (wave_on) begin
        if (ph <= 1) begin
          blink_a = ~blink_a;
          ph = blink_a ? hi_len : lo_len;
        end else begin
          ph = ph - 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // waits for a pin-level fall on blink_a, then pulses start_a in the low phase
  task automatic start_after_fall_a();
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = blink_a;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (!blink_a && prev) found = 1'b1;
      prev = blink_a;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_fall: no falling edge on blink_a, got found=%0d want 1", found);
    end
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy_a, valid_a, ovf_a} !== 3'b000 || period_a !== 27'd0 || high_a !== 27'd0) begin
      failures++;
      $display("FAIL reset_a: busy=%b valid=%b ovf=%b period=%0d high=%0d, want all 0",
               busy_a, valid_a, ovf_a, period_a, high_a);
    end
    checks++;
    if ({busy_b, valid_b, ovf_b} !== 3'b000 || period_b !== 4'd0 || high_b !== 4'd0) begin
      failures++;
      $display("FAIL reset_b: busy=%b valid=%b ovf=%b period=%0d high=%0d, want all 0",
               busy_b, valid_b, ovf_b, period_b, high_b);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_square();
    exp_t e;
    int   rises;
    bit   seen;
    logic prev;
    hi_len = 5; lo_len = 7; wave_on = 1'b1;
    repeat (30) @(negedge clk);
    sb_q.push_back('{period: 27'd12, high: 27'd5, ovf: 1'b0});
    start_after_fall_a();
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL square_busy: busy=%b want 1", busy_a);
    end
    rises = 0; seen = 1'b0; prev = blink_a;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (blink_a && !prev) rises++;
      prev = blink_a;
      if (valid_a) seen = 1'b1;
    end
    checks++;
    if (!seen || sb_q.size() == 0) begin
      failures++;
      $display("FAIL square_valid: valid seen=%0d queued=%0d, want 1 and 1", seen, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      checks++;
      if (period_a !== e.period || high_a !== e.high || ovf_a !== e.ovf) begin
        failures++;
        $display("FAIL square_result: period=%0d high=%0d ovf=%b, want %0d %0d %b",
                 period_a, high_a, ovf_a, e.period, e.high, e.ovf);
      end
      checks++;
      if (rises !== 2) begin
        failures++;
        $display("FAIL square_rises: pin rises before valid=%0d want 2", rises);
      end
    end
  endtask

  task automatic test_hold_ack();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_a = (i == 4);
      #1;
      checks++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || period_a !== last_exp.period || high_a !== last_exp.high) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b busy=%b period=%0d high=%0d, want 1 1 %0d %0d",
                 i, valid_a, busy_a, period_a, high_a, last_exp.period, last_exp.high);
      end
    end
    @(negedge clk); ack_a = 1'b1; start_a = 1'b1;
    @(negedge clk); ack_a = 1'b0; start_a = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL ack_release: valid=%b busy=%b want 0 0", valid_a, busy_a);
    end
    @(negedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || period_a !== last_exp.period || high_a !== last_exp.high) begin
      failures++;
      $display("FAIL start_dropped: busy=%b period=%0d high=%0d want 0 %0d %0d",
               busy_a, period_a, high_a, last_exp.period, last_exp.high);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    bit   seen;
    blink_b = 1'b0;
    repeat (5) @(negedge clk);
    sb_q.push_back('{period: 27'd15, high: 27'd15, ovf: 1'b1});
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      blink_b = (i >= 3 && i < 23) || (i >= 33);
      #1;
      if (valid_b) seen = 1'b1;
    end
    checks++;
    if (!seen || sb_q.size() == 0) begin
      failures++;
      $display("FAIL ovf_valid: valid seen=%0d queued=%0d, want 1 and 1", seen, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if ({23'd0, period_b} !== e.period || {23'd0, high_b} !== e.high || ovf_b !== e.ovf) begin
        failures++;
        $display("FAIL ovf_result: period=%0d high=%0d ovf=%b, want %0d %0d %b",
                 period_b, high_b, ovf_b, e.period, e.high, e.ovf);
      end
`ifdef BLINK_METER_TIMEOUT_EN
      checks++;
      if (to_b !== 1'b1) begin
        failures++;
        $display("FAIL ovf_timeout: timeout=%b want 1", to_b);
      end
`endif
    end
    @(negedge clk); ack_b = 1'b1;
    @(negedge clk); ack_b = 1'b0; blink_b = 1'b0;
  endtask

  task automatic test_rst_mid();
    exp_t e;
    bit   seen;
    bit   got;
    logic prev;
    hi_len = 5; lo_len = 7;
    start_after_fall_a();
    got = 1'b0; prev = blink_a;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (blink_a && !prev) got = 1'b1;
      prev = blink_a;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (!blink_a && prev) got = 1'b1;
      prev = blink_a;
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if ({busy_a, valid_a, ovf_a} !== 3'b000 || period_a !== 27'd0 || high_a !== 27'd0) begin
      failures++;
      $display("FAIL rst_mid: busy=%b valid=%b ovf=%b period=%0d high=%0d, want all 0",
               busy_a, valid_a, ovf_a, period_a, high_a);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (valid_a || busy_a) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_abort: valid or busy rose after reset, seen=%0d want 0", seen);
    end
    sb_q.push_back('{period: 27'd12, high: 27'd5, ovf: 1'b0});
    start_after_fall_a();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (valid_a) seen = 1'b1;
    end
    checks++;
    if (!seen || sb_q.size() == 0) begin
      failures++;
      $display("FAIL rst_fresh_valid: valid seen=%0d queued=%0d, want 1 and 1", seen, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (period_a !== e.period || high_a !== e.high || ovf_a !== e.ovf) begin
        failures++;
        $display("FAIL rst_fresh_result: period=%0d high=%0d ovf=%b, want %0d %0d %b",
                 period_a, high_a, ovf_a, e.period, e.high, e.ovf);
      end
    end
    @(negedge clk); ack_a = 1'b1;
    @(negedge clk); ack_a = 1'b0;
  endtask

  // toggle flop on a 16-cycle blink timer enable: 16 high, 16 low
  task automatic test_timer_toggle();
    exp_t e;
    bit   seen;
    hi_len = 16; lo_len = 16;
    repeat (70) @(negedge clk);
    sb_q.push_back('{period: 27'd32, high: 27'd16, ovf: 1'b0});
    start_after_fall_a();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (valid_a) seen = 1'b1;
    end
    checks++;
    if (!seen || sb_q.size() == 0) begin
      failures++;
      $display("FAIL toggle_valid: valid seen=%0d queued=%0d, want 1 and 1", seen, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (period_a !== e.period || high_a !== e.high || ovf_a !== e.ovf) begin
        failures++;
        $display("FAIL toggle_result: period=%0d high=%0d ovf=%b, want %0d %0d %b",
                 period_a, high_a, ovf_a, e.period, e.high, e.ovf);
      end
    end
    @(negedge clk); ack_a = 1'b1;
    @(negedge clk); ack_a = 1'b0;
  endtask

`ifdef BLINK_METER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bit seen;
    blink_b = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #1;
      cyc++;
      if (valid_b) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc !== 15) begin
      failures++;
      $display("FAIL timeout_latency: valid seen=%0d after %0d cycles, want 1 after 15", seen, cyc);
    end
    checks++;
    if (to_b !== 1'b1 || ovf_b !== 1'b1 || period_b !== 4'd15 || high_b !== 4'd15) begin
      failures++;
      $display("FAIL timeout_result: timeout=%b ovf=%b period=%0d high=%0d, want 1 1 15 15",
               to_b, ovf_b, period_b, high_b);
    end
    @(negedge clk); ack_b = 1'b1;
    @(negedge clk); ack_b = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    start_a = 1'b0; ack_a = 1'b0;
    start_b = 1'b0; ack_b = 1'b0; blink_b = 1'b0;
    test_reset();
    test_square();
    test_hold_ack();
    test_overflow();
    test_rst_mid();
    test_timer_toggle();
`ifdef BLINK_METER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
